// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL reset sequencer and the PLL / clock-domain consumers.
// The master side is the sequencer; the slave side owns the raw PLL lock.
interface pll_reset_sequencer_if;
  logic       pll_lock;
  logic       pll_resetb;
  logic       pll_bypass;
  logic       sys_reset;
  logic       ready;
  logic       fault;
  logic [1:0] retry_count;

  modport master (
    input  pll_lock,
    output pll_resetb,
    output pll_bypass,
    output sys_reset,
    output ready,
    output fault,
    output retry_count
  );

  modport slave (
    output pll_lock,
    input  pll_resetb,
    input  pll_bypass,
    input  sys_reset,
    input  ready,
    input  fault,
    input  retry_count
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Brings the PLL from power-up to a debounced lock on the reference clock, retrying on timeout,
// then releases the PLL-domain system reset. Lock loss restarts the sequence.
//
// state          | meaning
// ST_ASSERT_RST  | PLL held in reset for PLL_RESET_CYCLES
// ST_WAIT_LOCK   | PLL released, waiting for synchronized lock, attempt timer running
// ST_STABLE      | lock seen, counting consecutive lock samples, attempt timer running
// ST_RUN         | locked and stable, system reset released
// ST_FAULT       | retries exhausted, held until reset
module pll_reset_sequencer #(
  parameter int PLL_RESET_CYCLES    = 12,
  parameter int LOCK_TIMEOUT_CYCLES = 12000,
  parameter int LOCK_STABLE_CYCLES  = 64,
  parameter int MAX_RETRIES         = 3,
  parameter int BYPASS_ON_FAULT     = 0
) (
  input  logic                         reference_clk_i,
  input  logic                         reset_i,
  pll_reset_sequencer_if.master        pll
);

  localparam int RW = $clog2(PLL_RESET_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);

  localparam logic [RW-1:0] RST_LAST  = RW'(PLL_RESET_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_MAX   = TW'(LOCK_TIMEOUT_CYCLES);
  localparam logic [SW-1:0] STB_LAST  = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [SW-1:0] STB_MAX   = SW'(LOCK_STABLE_CYCLES);
  localparam logic [1:0]    RETRY_MAX = 2'(MAX_RETRIES);
  localparam logic          BYPASS    = (BYPASS_ON_FAULT != 0);
  localparam logic          STB_ONE   = (LOCK_STABLE_CYCLES == 1);

  typedef enum logic [2:0] {
    ST_ASSERT_RST,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN,
    ST_FAULT
  } state_e;

  state_e          state_q, state_d;
  logic            sync1_q;
  logic            lock_s_q;
  logic [RW-1:0]   rst_cnt_q, rst_cnt_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [SW-1:0]   stable_q, stable_d;
  logic [1:0]      retry_q, retry_d;

  logic            pll_resetb_q, pll_resetb_d;
  logic            sys_reset_q, sys_reset_d;
  logic            ready_q, ready_d;
  logic            fault_q, fault_d;
  logic            bypass_q, bypass_d;

  logic            expired;
  logic [TW-1:0]   timer_inc;
  logic [SW-1:0]   stable_inc;

  always_ff @(posedge reference_clk_i) begin
    if (reset_i) begin
      sync1_q      <= 1'b0;
      lock_s_q     <= 1'b0;
      state_q      <= ST_ASSERT_RST;
      rst_cnt_q    <= '0;
      timer_q      <= '0;
      stable_q     <= '0;
      retry_q      <= '0;
      pll_resetb_q <= 1'b0;
      sys_reset_q  <= 1'b1;
      ready_q      <= 1'b0;
      fault_q      <= 1'b0;
      bypass_q     <= 1'b0;
    end else begin
      sync1_q      <= pll.pll_lock;
      lock_s_q     <= sync1_q;
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      timer_q      <= timer_d;
      stable_q     <= stable_d;
      retry_q      <= retry_d;
      pll_resetb_q <= pll_resetb_d;
      sys_reset_q  <= sys_reset_d;
      ready_q      <= ready_d;
      fault_q      <= fault_d;
      bypass_q     <= bypass_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rst_cnt_d  = rst_cnt_q;
    timer_d    = timer_q;
    stable_d   = stable_q;
    retry_d    = retry_q;
    expired    = (timer_q == TMO_LAST);
    timer_inc  = (timer_q == TMO_MAX) ? timer_q : timer_q + TW'(1);
    stable_inc = (stable_q == STB_MAX) ? stable_q : stable_q + SW'(1);

    unique case (state_q)
      ST_ASSERT_RST: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d = ST_WAIT_LOCK;
          timer_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + RW'(1);
        end
      end

      ST_WAIT_LOCK, ST_STABLE: begin
        timer_d = timer_inc;
        // Timeout wins over a lock that completes on the same edge.
        if (expired) begin
          if (retry_q < RETRY_MAX) begin
            retry_d   = retry_q + 2'd1;
            rst_cnt_d = '0;
            state_d   = ST_ASSERT_RST;
          end else begin
            state_d = ST_FAULT;
          end
        end else if (state_q == ST_WAIT_LOCK) begin
          if (lock_s_q) begin
            stable_d = SW'(1);
            state_d  = STB_ONE ? ST_RUN : ST_STABLE;
          end
        end else if (!lock_s_q) begin
          state_d = ST_WAIT_LOCK;
        end else begin
          stable_d = stable_inc;
          if (stable_q == STB_LAST) begin
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        if (!lock_s_q) begin
          rst_cnt_d = '0;
          state_d   = ST_ASSERT_RST;
        end
      end

      ST_FAULT: begin
        state_d = ST_FAULT;
      end

      default: begin
        rst_cnt_d = '0;
        state_d   = ST_ASSERT_RST;
      end
    endcase

    if (state_d == ST_RUN && state_q != ST_RUN) begin
      retry_d = '0;
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    pll_resetb_d = 1'b1;
    sys_reset_d  = 1'b1;
    ready_d      = 1'b0;
    fault_d      = 1'b0;
    bypass_d     = 1'b0;
    unique case (state_d)
      ST_ASSERT_RST: pll_resetb_d = 1'b0;
      ST_RUN: begin
        sys_reset_d = 1'b0;
        ready_d     = 1'b1;
      end
      ST_FAULT: begin
        fault_d      = 1'b1;
        pll_resetb_d = BYPASS;
        bypass_d     = BYPASS;
        sys_reset_d  = !BYPASS;
      end
      default: ;
    endcase
  end

  assign pll.pll_resetb  = pll_resetb_q;
  assign pll.sys_reset   = sys_reset_q;
  assign pll.ready       = ready_q;
  assign pll.fault       = fault_q;
  assign pll.pll_bypass  = bypass_q;
  assign pll.retry_count = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer; edge numbers count from the last edge with RESET high.
// A second instance with bypass-on-fault shares all stimulus.
module tb_pll_reset_sequencer;

  logic clk;
  logic rst;
  logic lock;
  int   n_vec;
  int   n_err;
  int   ecnt;

  pll_reset_sequencer_if bus_a ();
  pll_reset_sequencer_if bus_b ();

  assign bus_a.pll_lock = lock;
  assign bus_b.pll_lock = lock;

  pll_reset_sequencer #(
    .PLL_RESET_CYCLES(4), .LOCK_TIMEOUT_CYCLES(20), .LOCK_STABLE_CYCLES(8),
    .MAX_RETRIES(2), .BYPASS_ON_FAULT(0)
  ) dut_a (
    .reference_clk_i(clk),
    .reset_i        (rst),
    .pll            (bus_a)
  );

  pll_reset_sequencer #(
    .PLL_RESET_CYCLES(4), .LOCK_TIMEOUT_CYCLES(20), .LOCK_STABLE_CYCLES(8),
    .MAX_RETRIES(2), .BYPASS_ON_FAULT(1)
  ) dut_b (
    .reference_clk_i(clk),
    .reset_i        (rst),
    .pll            (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic to(input int n);
    while (ecnt < n) begin
      @(posedge clk);
      #1;
      ecnt++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst  = 1'b0;
    ecnt = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " resetb"}, 32'(bus_a.pll_resetb), 32'd0);
    chk({tag, " sysrst"}, 32'(bus_a.sys_reset), 32'd1);
    chk({tag, " ready"},  32'(bus_a.ready), 32'd0);
    chk({tag, " fault"},  32'(bus_a.fault), 32'd0);
    chk({tag, " bypass"}, 32'(bus_a.pll_bypass), 32'd0);
    chk({tag, " retry"},  32'(bus_a.retry_count), 32'd0);
    chk({tag, " b_fault"}, 32'(bus_b.fault), 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    ecnt  = 0;
    lock  = 1'b0;

    // reset state
    do_reset();
    chk_reset_vals("rst");

    // clean lock: lock rises after edge 10, READY at edge 20
    to(3);  chk("clean resetb@3", 32'(bus_a.pll_resetb), 32'd0);
    to(4);  chk("clean resetb@4", 32'(bus_a.pll_resetb), 32'd1);
            chk("clean sysrst@4", 32'(bus_a.sys_reset), 32'd1);
    to(10); lock = 1'b1;
    to(19); chk("clean ready@19", 32'(bus_a.ready), 32'd0);
    to(20); chk("clean ready@20", 32'(bus_a.ready), 32'd1);
            chk("clean sysrst@20", 32'(bus_a.sys_reset), 32'd0);
            chk("clean retry@20", 32'(bus_a.retry_count), 32'd0);
            chk("clean fault@20", 32'(bus_a.fault), 32'd0);

    // lock loss in RUN: one-cycle drop after edge 22 -> back to reset at edge 25
    to(22); lock = 1'b0;
    to(23); lock = 1'b1;
    to(24); chk("loss ready@24", 32'(bus_a.ready), 32'd1);
    to(25); chk("loss ready@25", 32'(bus_a.ready), 32'd0);
            chk("loss sysrst@25", 32'(bus_a.sys_reset), 32'd1);
            chk("loss resetb@25", 32'(bus_a.pll_resetb), 32'd0);
    to(28); chk("loss resetb@28", 32'(bus_a.pll_resetb), 32'd0);
    to(29); chk("loss resetb@29", 32'(bus_a.pll_resetb), 32'd1);
    to(36); chk("loss ready@36", 32'(bus_a.ready), 32'd0);
    to(37); chk("loss ready@37", 32'(bus_a.ready), 32'd1);
            chk("loss retry@37", 32'(bus_a.retry_count), 32'd0);

    // glitchy lock: high 5 samples, low 1, then high; STABLE restarts at edge 13
    lock = 1'b0;
    do_reset();
    to(4);  lock = 1'b1;
    to(9);  lock = 1'b0;
    to(10); lock = 1'b1;
    to(14); chk("glitch ready@14", 32'(bus_a.ready), 32'd0);
    to(19); chk("glitch ready@19", 32'(bus_a.ready), 32'd0);
    to(20); chk("glitch ready@20", 32'(bus_a.ready), 32'd1);
            chk("glitch retry@20", 32'(bus_a.retry_count), 32'd0);

    // timeout and stable completion on the same edge (24): timeout wins
    lock = 1'b0;
    do_reset();
    to(14); lock = 1'b1;
    to(23); chk("prio ready@23", 32'(bus_a.ready), 32'd0);
    to(24); chk("prio ready@24", 32'(bus_a.ready), 32'd0);
            chk("prio resetb@24", 32'(bus_a.pll_resetb), 32'd0);
            chk("prio retry@24", 32'(bus_a.retry_count), 32'd1);
    to(35); chk("prio retry@35", 32'(bus_a.retry_count), 32'd1);
            chk("prio ready@35", 32'(bus_a.ready), 32'd0);
    to(36); chk("prio ready@36", 32'(bus_a.ready), 32'd1);
            chk("prio retry@36", 32'(bus_a.retry_count), 32'd0);

    // never locks: attempts start at 4, 28, 52; fault at 72
    lock = 1'b0;
    do_reset();
    to(4);  chk("never resetb@4", 32'(bus_a.pll_resetb), 32'd1);
    to(23); chk("never retry@23", 32'(bus_a.retry_count), 32'd0);
            chk("never resetb@23", 32'(bus_a.pll_resetb), 32'd1);
    to(24); chk("never resetb@24", 32'(bus_a.pll_resetb), 32'd0);
            chk("never retry@24", 32'(bus_a.retry_count), 32'd1);
    to(27); chk("never resetb@27", 32'(bus_a.pll_resetb), 32'd0);
    to(28); chk("never resetb@28", 32'(bus_a.pll_resetb), 32'd1);
    to(47); chk("never retry@47", 32'(bus_a.retry_count), 32'd1);
    to(48); chk("never resetb@48", 32'(bus_a.pll_resetb), 32'd0);
            chk("never retry@48", 32'(bus_a.retry_count), 32'd2);
    to(52); chk("never resetb@52", 32'(bus_a.pll_resetb), 32'd1);
    to(71); chk("never fault@71", 32'(bus_a.fault), 32'd0);
            chk("never b_fault@71", 32'(bus_b.fault), 32'd0);
    to(72); chk("never fault@72", 32'(bus_a.fault), 32'd1);
            chk("never sysrst@72", 32'(bus_a.sys_reset), 32'd1);
            chk("never resetb@72", 32'(bus_a.pll_resetb), 32'd0);
            chk("never bypass@72", 32'(bus_a.pll_bypass), 32'd0);
            chk("never ready@72", 32'(bus_a.ready), 32'd0);
            chk("never retry@72", 32'(bus_a.retry_count), 32'd2);
            chk("byp fault@72", 32'(bus_b.fault), 32'd1);
            chk("byp bypass@72", 32'(bus_b.pll_bypass), 32'd1);
            chk("byp sysrst@72", 32'(bus_b.sys_reset), 32'd0);
            chk("byp ready@72", 32'(bus_b.ready), 32'd0);
            chk("byp resetb@72", 32'(bus_b.pll_resetb), 32'd1);
    to(90); chk("never fault@90", 32'(bus_a.fault), 32'd1);
            chk("byp bypass@90", 32'(bus_b.pll_bypass), 32'd1);

    // reset mid-sequence: leaves FAULT, then a one-cycle reset while in STABLE
    do_reset();
    chk_reset_vals("fltrst");
    to(4);  lock = 1'b1;
    to(9);  rst = 1'b1;
    to(10);
    chk_reset_vals("midrst");
    rst  = 1'b0;
    ecnt = 0;
    to(3);  chk("midrst resetb@3", 32'(bus_a.pll_resetb), 32'd0);
    to(4);  chk("midrst resetb@4", 32'(bus_a.pll_resetb), 32'd1);
    to(11); chk("midrst ready@11", 32'(bus_a.ready), 32'd0);
    to(12); chk("midrst ready@12", 32'(bus_a.ready), 32'd1);

    // success on last retry: lock rises after edge 55, RUN at edge 65
    lock = 1'b0;
    do_reset();
    to(55); lock = 1'b1;
    to(57); chk("last retry@57", 32'(bus_a.retry_count), 32'd2);
    to(64); chk("last retry@64", 32'(bus_a.retry_count), 32'd2);
            chk("last ready@64", 32'(bus_a.ready), 32'd0);
    to(65); chk("last ready@65", 32'(bus_a.ready), 32'd1);
            chk("last fault@65", 32'(bus_a.fault), 32'd0);
            chk("last retry@65", 32'(bus_a.retry_count), 32'd0);
            chk("last sysrst@65", 32'(bus_a.sys_reset), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
